// File: rtl/mem_bus_master.sv
// Memory bus initiator: turns one CPU load/store at a time into a single aligned
// word transaction, then returns an extended load result or completion strobe.
module mem_bus_master #(
  parameter int READ_LATENCY = 1,
  parameter int TIMEOUT      = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] address,
  output logic [3:0]  byteenable,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);
  // Handshake: a request transfers on a posedge with req_valid & req_ready;
  // req_ready is high only in IDLE, so at most one transaction is in flight.
  typedef enum logic [1:0] {IDLE, BUS, LAT, RESP} state_t;

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t        state, state_d;
  logic          read_d, write_d, resp_valid_d, resp_err_d;
  logic [31:0]   address_d, writedata_d, resp_rdata_d;
  logic [3:0]    byteenable_d;
  logic [TW-1:0] to_cnt, to_cnt_d;
  logic [2:0]    lat_cnt, lat_cnt_d;
  logic [1:0]    lat_size, lat_size_d, lat_off, lat_off_d;
  logic          lat_signed, lat_signed_d;

  logic          bad_req;
  logic [3:0]    be_c;
  logic [31:0]   lane_mask, wd_rep, wd_c;
  logic [31:0]   shifted, load_ext;

  assign req_ready = (state == IDLE);

  always_comb begin
    bad_req = 1'b0;
    be_c    = 4'b0000;
    wd_rep  = req_wdata;
    case (req_size)
      2'b00: begin
        be_c   = 4'b0001 << req_addr[1:0];
        wd_rep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_c    = req_addr[1] ? 4'b1100 : 4'b0011;
        wd_rep  = {2{req_wdata[15:0]}};
        bad_req = req_addr[0];
      end
      2'b10: begin
        be_c    = 4'b1111;
        bad_req = (req_addr[1:0] != 2'b00);
      end
      default: bad_req = 1'b1;
    endcase
    lane_mask = {{8{be_c[3]}}, {8{be_c[2]}}, {8{be_c[1]}}, {8{be_c[0]}}};
    wd_c      = wd_rep & lane_mask;
  end

  // Half offsets are 0 or 2, so a byte-granular shift covers both sizes.
  always_comb begin
    shifted  = readdata >> {lat_off, 3'b000};
    load_ext = readdata;
    case (lat_size)
      2'b00:   load_ext = {{24{lat_signed & shifted[7]}}, shifted[7:0]};
      2'b01:   load_ext = {{16{lat_signed & shifted[15]}}, shifted[15:0]};
      default: load_ext = readdata;
    endcase
  end

  always_comb begin
    state_d      = state;
    read_d       = read;
    write_d      = write;
    address_d    = address;
    byteenable_d = byteenable;
    writedata_d  = writedata;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata;
    resp_err_d   = resp_err;
    to_cnt_d     = to_cnt;
    lat_cnt_d    = lat_cnt;
    lat_size_d   = lat_size;
    lat_off_d    = lat_off;
    lat_signed_d = lat_signed;
    case (state)
      IDLE: if (req_valid) begin
        lat_size_d   = req_size;
        lat_off_d    = req_addr[1:0];
        lat_signed_d = req_signed;
        if (bad_req) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_rdata_d = 32'd0;
        end else begin
          state_d      = BUS;
          read_d       = ~req_write;
          write_d      = req_write;
          address_d    = {req_addr[31:2], 2'b00};
          byteenable_d = be_c;
          writedata_d  = req_write ? wd_c : 32'd0;
          to_cnt_d     = '0;
        end
      end
      BUS: begin
        if (!waitrequest) begin
          read_d   = 1'b0;
          write_d  = 1'b0;
          to_cnt_d = '0;
          if (write) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b0;
            resp_rdata_d = 32'd0;
          end else begin
            state_d   = LAT;
            lat_cnt_d = 3'(READ_LATENCY);
          end
        end else if (TIMEOUT != 0 && to_cnt == TO_LAST) begin
          read_d       = 1'b0;
          write_d      = 1'b0;
          to_cnt_d     = '0;
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_rdata_d = 32'd0;
        end else begin
          to_cnt_d = to_cnt + 1'b1;
        end
      end
      // The edge where the count would reach zero is the readdata sample edge.
      LAT: begin
        if (lat_cnt <= 3'd1) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = load_ext;
          lat_cnt_d    = 3'd0;
        end else begin
          lat_cnt_d = lat_cnt - 3'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      read       <= 1'b0;
      write      <= 1'b0;
      address    <= 32'd0;
      byteenable <= 4'd0;
      writedata  <= 32'd0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      to_cnt     <= '0;
      lat_cnt    <= 3'd0;
      lat_size   <= 2'd0;
      lat_off    <= 2'd0;
      lat_signed <= 1'b0;
    end else begin
      state      <= state_d;
      read       <= read_d;
      write      <= write_d;
      address    <= address_d;
      byteenable <= byteenable_d;
      writedata  <= writedata_d;
      resp_valid <= resp_valid_d;
      resp_rdata <= resp_rdata_d;
      resp_err   <= resp_err_d;
      to_cnt     <= to_cnt_d;
      lat_cnt    <= lat_cnt_d;
      lat_size   <= lat_size_d;
      lat_off    <= lat_off_d;
      lat_signed <= lat_signed_d;
    end
  end
endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench for mem_bus_master (READ_LATENCY=1, TIMEOUT=4); inputs change
// and outputs are checked on the falling edge.
module tb_mem_bus_master;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata, address, writedata;
  logic [3:0]  byteenable;
  logic        read, write;
  logic        waitrequest = 1'b0;
  logic [31:0] readdata = 32'd0;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mem_bus_master #(.READ_LATENCY(1), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .address(address), .byteenable(byteenable),
    .read(read), .write(write), .writedata(writedata),
    .waitrequest(waitrequest), .readdata(readdata)
  );

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata);
    chk1("req_ready_before", req_ready, 1'b1);
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    @(negedge clk);
    req_valid  = 1'b0;
  endtask

  // Called just after the acceptance edge; counts falling edges until resp_valid.
  task automatic wait_resp(input int exp_lat, input logic exp_err);
    int lat;
    logic [31:0] exp_d;
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 16) begin
      @(negedge clk);
      lat++;
    end
    exp_d = exp_q.pop_front();
    chk32("resp_latency", 32'(lat), 32'(exp_lat));
    chk1("resp_valid", resp_valid, 1'b1);
    chk1("resp_err", resp_err, exp_err);
    chk32("resp_rdata", resp_rdata, exp_d);
    @(negedge clk);
    chk1("resp_valid_drop", resp_valid, 1'b0);
    chk32("resp_rdata_hold", resp_rdata, exp_d);
    chk1("resp_err_hold", resp_err, exp_err);
    chk1("req_ready_after", req_ready, 1'b1);
  endtask

  task automatic do_load(input logic [1:0] size, input logic sgn, input logic [31:0] addr,
                         input logic [31:0] rd, input logic [3:0] exp_be,
                         input logic [31:0] exp_data);
    waitrequest = 1'b0;
    readdata    = rd;
    exp_q.push_back(exp_data);
    issue(1'b0, size, sgn, addr, 32'd0);
    chk1("load_read", read, 1'b1);
    chk1("load_write", write, 1'b0);
    chk32("load_address", address, {addr[31:2], 2'b00});
    chk32("load_be", 32'(byteenable), 32'(exp_be));
    wait_resp(2, 1'b0);
  endtask

  task automatic do_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd);
    waitrequest = 1'b0;
    exp_q.push_back(32'd0);
    issue(1'b1, size, 1'b0, addr, wd);
    chk1("store_write", write, 1'b1);
    chk1("store_read", read, 1'b0);
    chk32("store_address", address, {addr[31:2], 2'b00});
    chk32("store_be", 32'(byteenable), 32'(exp_be));
    chk32("store_wdata", writedata, exp_wd);
    wait_resp(1, 1'b0);
    chk1("store_write_drop", write, 1'b0);
  endtask

  task automatic do_bad(input logic wr, input logic [1:0] size, input logic [31:0] addr);
    exp_q.push_back(32'd0);
    issue(wr, size, 1'b0, addr, 32'hFFFF_FFFF);
    chk1("bad_read", read, 1'b0);
    chk1("bad_write", write, 1'b0);
    wait_resp(0, 1'b1);
    chk1("bad_read_after", read, 1'b0);
    chk1("bad_write_after", write, 1'b0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk1("rst_read", read, 1'b0);
    chk1("rst_write", write, 1'b0);
    chk1("rst_resp_valid", resp_valid, 1'b0);
    chk1("rst_resp_err", resp_err, 1'b0);
    chk32("rst_address", address, 32'd0);
    chk32("rst_be", 32'(byteenable), 32'd0);
    chk32("rst_writedata", writedata, 32'd0);
    chk32("rst_resp_rdata", resp_rdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk1("rst_req_ready", req_ready, 1'b1);

    // Word read with three stalled edges
    waitrequest = 1'b1;
    readdata    = 32'h1234_5678;
    exp_q.push_back(32'h1234_5678);
    issue(1'b0, 2'b10, 1'b0, 32'hBFC0_0010, 32'd0);
    chk1("wr_read_0", read, 1'b1);
    chk1("wr_req_ready_busy", req_ready, 1'b0);
    chk32("wr_address_0", address, 32'hBFC0_0010);
    chk32("wr_be_0", 32'(byteenable), 32'hF);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk1("wr_read_stall", read, 1'b1);
      chk32("wr_address_stall", address, 32'hBFC0_0010);
      chk32("wr_be_stall", 32'(byteenable), 32'hF);
    end
    waitrequest = 1'b0;
    wait_resp(2, 1'b0);
    chk1("wr_read_done", read, 1'b0);

    // Stores
    do_store(2'b00, 32'h0000_1003, 32'h0000_00AB, 4'b1000, 32'hAB00_0000);
    do_store(2'b01, 32'h0000_0002, 32'h1234_BEEF, 4'b1100, 32'hBEEF_0000);
    do_store(2'b10, 32'h0000_0020, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);

    // Load extraction
    do_load(2'b00, 1'b1, 32'h0000_0402, 32'h0080_0000, 4'b0100, 32'hFFFF_FF80);
    do_load(2'b00, 1'b0, 32'h0000_0402, 32'h0080_0000, 4'b0100, 32'h0000_0080);
    do_load(2'b01, 1'b1, 32'h0000_0402, 32'h8001_0000, 4'b1100, 32'hFFFF_8001);
    do_load(2'b00, 1'b0, 32'h0000_0401, 32'h0000_CD00, 4'b0010, 32'h0000_00CD);
    do_load(2'b01, 1'b0, 32'h0000_0400, 32'h0000_9876, 4'b0011, 32'h0000_9876);

    // Illegal and misaligned requests
    do_bad(1'b0, 2'b01, 32'h0000_0001);
    do_bad(1'b0, 2'b11, 32'h0000_0000);
    do_bad(1'b1, 2'b10, 32'h0000_0006);

    // Timeout after four stalled edges
    waitrequest = 1'b1;
    exp_q.push_back(32'd0);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'd0);
    repeat (3) @(negedge clk);
    chk1("to_read_stall3", read, 1'b1);
    wait_resp(1, 1'b1);
    chk1("to_read_abort", read, 1'b0);
    waitrequest = 1'b0;

    // Reset during the second stall cycle
    waitrequest = 1'b1;
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'd0);
    @(negedge clk);
    chk1("mr_read_stall1", read, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk1("mr_read", read, 1'b0);
    chk32("mr_address", address, 32'd0);
    chk32("mr_be", 32'(byteenable), 32'd0);
    chk1("mr_resp_valid", resp_valid, 1'b0);
    waitrequest = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk1("mr_no_resp", resp_valid, 1'b0);
    end
    chk1("mr_req_ready", req_ready, 1'b1);
    do_load(2'b10, 1'b0, 32'h0000_0008, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
